seven_segment_display_ctrl: RTL
===============================

// Module: seven_segment_display_ctrl
// PURPOSE
//  Registered, parametrised hex display controller for NUM_DIGITS seven-segment digits.
//  Accepts a display frame via valid/ready handshake and scans digits MSB->LSB, one per cycle.
//  Applies leading-zero blanking and hex decode, then commits all digits atomically.
//  Sits between status/debug logic and the board's active-low segment pins.
// PARAMETERS
//  NUM_DIGITS  8           digits driven; >=1
//  BLINK_HALF  25_000_000  clock cycles per blink half-period (only with SEVSEG_BLINK_EN); >=1
// PORTS
//  clock        in   1              system clock; all logic on posedge
//  reset        in   1              synchronous, active-high reset
//  load_valid   in   1              frame offered this cycle
//  load_ready   out  1              controller idle, frame accepted when valid&&ready
//  value        in   NUM_DIGITS*4   packed [NUM_DIGITS-1:0][3:0], nibble per digit; [0] = rightmost
//  en           in   NUM_DIGITS     per-digit enable; 0 = digit blank
//  lzb          in   1              leading-zero blanking enable for this frame
//  blink_mask   in   NUM_DIGITS     per-digit blink select (port exists only with SEVSEG_BLINK_EN)
//  update_done  out  1              1-cycle pulse when a frame is committed to segment
//  segment      out  NUM_DIGITS*7   packed [NUM_DIGITS-1:0][6:0], active-low
// BEHAVIOUR
//  Encoding: bit0=a(top), bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g(middle); 0 = lit.
//   Glyphs 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex). Blank = 7'h7F.
//  Reset (reset=1 at an edge): state IDLE; segment all 7'h7F; update_done=0.
//   load_ready=0 while reset is asserted; load_ready=1 from the first cycle after.
//  Reset mid-operation: in-flight frame discarded; outputs return to reset values.
//  FSM IDLE -> SCAN -> COMMIT -> IDLE:
//   IDLE:   load_ready=1. On load_valid&&load_ready, capture value, en and lzb into a shadow.
//           Set idx=NUM_DIGITS-1 and zrun=lzb. Go to SCAN.
//           Inputs are sampled only at acceptance; later changes are ignored.
//   SCAN:   load_ready=0. One digit per cycle, idx counts down.
//           en[idx]=0           -> stage[idx]=blank; zrun unchanged.
//           zrun && v[idx]==0 && idx!=0 -> stage[idx]=blank.
//           Otherwise           -> stage[idx]=glyph(v[idx]); zrun=0.
//           Digit 0 is never blanked by LZB, so an all-zero frame shows "0".
//           After idx=0 is processed, go to COMMIT.
//   COMMIT: load_ready=0. segment_reg <= stage (all digits in the same edge); update_done=1.
//           Go to IDLE.
//  Latency: frame accepted at edge k; SCAN occupies edges k+1..k+N; COMMIT at edge k+N+1.
//   New segment and update_done are visible after edge k+N+1. load_ready returns 1 the cycle after.
//   Throughput: one frame per N+2 cycles. segment holds the last committed frame indefinitely.
//  load_valid while not ready: no effect; the producer must hold the frame.
//  Widths: idx is $clog2(NUM_DIGITS) bits, min 1. No arithmetic overflow paths.
// CONFIGURATION
//  `SEVSEG_BLINK_EN defined:
//   - blink_mask port is present.
//   - Free-running counter 0..BLINK_HALF-1 cleared by reset.
//   - phase toggles on wrap (phase=0 after reset = visible).
//   - segment[i] = (blink_mask[i] && phase) ? 7'h7F : segment_reg[i]. This is a registered output.
//   - blink_mask is applied live, not snapshotted; a blink-forced blank does not affect LZB.
//  Undefined: no blink_mask port, no counter; segment = segment_reg.
// TESTING
//  1 reset asserted mid-SCAN -> segment all 7'h7F, update_done=0;
//    load_ready=1 the cycle after reset deasserts.
//  2 N=8, value=32'h0000_00A5, en=8'hFF, lzb=1 -> digits 7..2 = 7F, [1]=08, [0]=12;
//    update_done exactly 9 cycles after accept.
//  3 value=0, lzb=1, en=FF -> only [0]=40, others 7F; same frame with lzb=0 -> all 40.
//  4 en=8'b1111_0111, value=32'h1234_5678, lzb=0 -> [3]=7F, rest glyphs; inputs changed
//    during SCAN -> no effect on committed frame.
//  5 back-to-back load_valid held high -> accepts every 10 cycles (N=8);
//    segment never shows a mix of two frames.
//  6 SEVSEG_BLINK_EN, BLINK_HALF=4, blink_mask=8'h01 -> [0] toggles glyph/7F every 4 cycles,
//    other digits steady.

Source files
------------

// File: rtl/seven_segment_display_ctrl.sv
// Hex display controller: accepts a frame, scans digits MSB->LSB with leading-zero blanking,
// then commits all digits at once. Optional blinking enabled by defining SEVSEG_BLINK_EN.
module seven_segment_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BLINK_HALF = 25_000_000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [NUM_DIGITS-1:0][3:0] value,
    input  logic [NUM_DIGITS-1:0]      en,
    input  logic                       lzb,
`ifdef SEVSEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]      blink_mask,
`endif
    output logic                       update_done,
    output logic [NUM_DIGITS-1:0][6:0] segment
);

    localparam int unsigned IDXW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0]  BLANK = 7'h7F;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]                 state;
    logic [IDXW-1:0]            idx;
    logic                       zrun;
    logic [NUM_DIGITS-1:0][3:0] sh_value;
    logic [NUM_DIGITS-1:0]      sh_en;
    logic [NUM_DIGITS-1:0][6:0] stage;
    logic [NUM_DIGITS-1:0][6:0] segment_reg;
    logic                       done_q;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    assign load_ready  = (state == ST_IDLE) && !reset;
    assign update_done = done_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            zrun        <= 1'b0;
            sh_value    <= '0;
            sh_en       <= '0;
            stage       <= {NUM_DIGITS{BLANK}};
            segment_reg <= {NUM_DIGITS{BLANK}};
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_valid) begin
                        sh_value <= value;
                        sh_en    <= en;
                        zrun     <= lzb;
                        idx      <= IDXW'(NUM_DIGITS - 1);
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // zrun survives disabled digits; digit 0 always shows a glyph when enabled
                    if (!sh_en[idx]) begin
                        stage[idx] <= BLANK;
                    end else if (zrun && (sh_value[idx] == 4'h0) && (idx != '0)) begin
                        stage[idx] <= BLANK;
                    end else begin
                        stage[idx] <= glyph(sh_value[idx]);
                        zrun       <= 1'b0;
                    end
                    if (idx == '0) begin
                        state <= ST_COMMIT;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                ST_COMMIT: begin
                    segment_reg <= stage;
                    done_q      <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SEVSEG_BLINK_EN
    localparam int unsigned CNTW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [CNTW-1:0]            blink_cnt;
    logic                       phase;
    logic                       phase_next;
    logic [NUM_DIGITS-1:0][6:0] seg_next;
    logic [NUM_DIGITS-1:0][6:0] segment_q;

    // Output register is fed from next-state values so commit latency is unchanged
    always_comb begin
        phase_next = (blink_cnt == CNTW'(BLINK_HALF - 1)) ? ~phase : phase;
        seg_next   = (state == ST_COMMIT) ? stage : segment_reg;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
            segment_q <= {NUM_DIGITS{BLANK}};
        end else begin
            blink_cnt <= (blink_cnt == CNTW'(BLINK_HALF - 1)) ? '0 : blink_cnt + 1'b1;
            phase     <= phase_next;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                segment_q[i] <= (blink_mask[i] && phase_next) ? BLANK : seg_next[i];
            end
        end
    end

    assign segment = segment_q;
`else
    assign segment = segment_reg;
`endif

endmodule
